tensor_host_sequencer: RTL and testbench

Host-side driver for the tensor-core CPU's 16-bit instruction port.
- Accepts two signed 3x3 int8 matrices and an operation select.
- Emits the complete instruction stream: load-immediate x18, one operate, NOP wait, generic read x9.
- Reassembles the 8-bit read-back bytes into a 3x3 result, then hands it upstream over a valid/ready handshake.
- Sits between the testbench or SoC fabric and the CPU: instruction_out drives the CPU instruction input, and the CPU output drives cpu_data_in.

---
 rtl/tensor_host_sequencer_pkg.sv | 53 +++++
 rtl/tensor_host_sequencer_if.sv | 36 +++
 rtl/tensor_host_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tensor_host_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_host_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | tensor_host_pkg                                                      |
// | Instruction encodings, state enum and helpers for the host sequencer |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package tensor_host_pkg;

  localparam int MAT_W = 72;

  localparam logic [1:0] OPC_GENERIC  = 2'b00;
  localparam logic [1:0] OPC_LOADI    = 2'b01;
  localparam logic [1:0] OPC_OPERATE  = 2'b10;
  localparam logic [1:0] OPC_RESERVED = 2'b11;

  // Generic-opcode selects live in instruction bits [3:2]
  localparam logic [1:0] GSEL_NOP   = 2'b00;
  localparam logic [1:0] GSEL_MOVE  = 2'b01;
  localparam logic [1:0] GSEL_READ  = 2'b10;
  localparam logic [1:0] GSEL_RESET = 2'b11;

  localparam logic [15:0] INSTR_NOP   = 16'h0000;
  localparam logic [15:0] INSTR_RESET = {12'h000, GSEL_RESET, OPC_GENERIC};

  localparam logic [4:0] MATRIX1_BASE = 5'd0;
  localparam logic [4:0] MATRIX2_BASE = 5'd9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_ISSUE = 3'd1,
    S_LOAD      = 3'd2,
    S_OPERATE   = 3'd3,
    S_WAIT      = 3'd4,
    S_READ      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  function automatic logic [15:0] encode_loadi(input logic [4:0] addr, input logic [7:0] data);
    return {addr, data, 1'b0, OPC_LOADI};
  endfunction

  function automatic logic [15:0] encode_operate(input logic [2:0] opsel);
    return {11'b0, opsel, OPC_OPERATE};
  endfunction

  function automatic logic [15:0] encode_read(input logic [4:0] addr);
    return {5'b0, addr, 2'b00, GSEL_READ, OPC_GENERIC};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tensor_host_sequencer_if.sv
// +----------------------------------------------------------------------+
// | tensor_host_sequencer_if                                             |
// | Host job/result handshake plus the CPU instruction/data port         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface tensor_host_sequencer_if;
  import tensor_host_pkg::*;

  logic             start_in;
  logic             ready_out;
  logic [2:0]       operation_select_in;
  logic [MAT_W-1:0] matrix1_in;
  logic [MAT_W-1:0] matrix2_in;
  logic [15:0]      instruction_out;
  logic [7:0]       cpu_data_in;
  logic             result_valid_out;
  logic             result_ready_in;
  logic [MAT_W-1:0] result_data_out;

  modport slave (
    input  start_in, operation_select_in, matrix1_in, matrix2_in,
    input  cpu_data_in, result_ready_in,
    output ready_out, instruction_out, result_valid_out, result_data_out
  );

  modport master (
    output start_in, operation_select_in, matrix1_in, matrix2_in,
    output cpu_data_in, result_ready_in,
    input  ready_out, instruction_out, result_valid_out, result_data_out
  );

endinterface

`default_nettype wire

// File: rtl/tensor_host_sequencer.sv
// +----------------------------------------------------------------------+
// | tensor_host_sequencer                                                |
// | Streams LOADI/OPERATE/NOP/READ to the tensor CPU and collects the    |
// | 3x3 int8 result. Option: TENSOR_HOST_SEQ_RESET_EN adds a RESET issue.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tensor_host_sequencer
  import tensor_host_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input logic                    clock_in,
  input logic                    reset_in,
  tensor_host_sequencer_if.slave bus
);

  localparam logic [4:0] c_LOAD_LAST = 5'd17;
  localparam logic [4:0] c_READ_LAST = 5'd8;
  localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  // The CPU bulk write lands 4 cycles after OPERATE; a shorter wait reads stale data
  generate
    if (WAIT_CYCLES < 4 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("tensor_host_sequencer: WAIT_CYCLES must be within 4..15");
    end
  endgenerate

  state_t           r_state;
  logic [4:0]       r_idx;
  logic [3:0]       r_wait;
  logic [2:0]       r_opsel;
  logic [143:0]     r_mats;
  logic [15:0]      r_instr;
  logic             r_valid;
  logic [MAT_W-1:0] r_result;

  state_t           w_state_nxt;
  logic [4:0]       w_idx_nxt;
  logic [3:0]       w_wait_nxt;
  logic             w_latch;
  logic             w_cap;
  logic             w_valid_nxt;
  logic             w_ready;
  logic [143:0]     w_mats_src;
  logic [7:0]       w_elem;
  logic [15:0]      w_instr_nxt;

  assign w_ready    = (r_state == S_IDLE) && !r_valid;
  // The first LOADI leaves on the accept edge, before r_mats holds the inputs
  assign w_mats_src = w_latch ? {bus.matrix2_in, bus.matrix1_in} : r_mats;
  assign w_elem     = w_mats_src[{w_idx_nxt, 3'b000} +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    w_valid_nxt = r_valid;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_in && w_ready) begin
          w_latch   = 1'b1;
          w_idx_nxt = '0;
`ifdef TENSOR_HOST_SEQ_RESET_EN
          w_state_nxt = S_RST_ISSUE;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
      S_RST_ISSUE: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = '0;
      end
      S_LOAD: begin
        if (r_idx == c_LOAD_LAST) begin
          w_state_nxt = S_OPERATE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      S_OPERATE: begin
        w_state_nxt = S_WAIT;
        w_idx_nxt   = '0;
        w_wait_nxt  = '0;
      end
      S_WAIT: begin
        if (r_wait == c_WAIT_LAST) begin
          w_state_nxt = S_READ;
          w_idx_nxt   = '0;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      S_READ: begin
        // cpu_data_in answers the READ currently on the bus, tagged by r_idx
        w_cap = 1'b1;
        if (r_idx == c_READ_LAST) begin
          w_state_nxt = S_DONE;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      S_DONE: begin
        if (bus.result_ready_in) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Instruction is a function of the state being entered so it registers with it
  always_comb begin
    w_instr_nxt = INSTR_NOP;
    unique case (w_state_nxt)
      S_RST_ISSUE: w_instr_nxt = INSTR_RESET;
      S_LOAD:      w_instr_nxt = encode_loadi(MATRIX1_BASE + w_idx_nxt, w_elem);
      S_OPERATE:   w_instr_nxt = encode_operate(r_opsel);
      S_READ:      w_instr_nxt = encode_read(w_idx_nxt);
      default:     w_instr_nxt = INSTR_NOP;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wait   <= '0;
      r_opsel  <= '0;
      r_mats   <= '0;
      r_instr  <= INSTR_NOP;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wait  <= w_wait_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      if (w_latch) begin
        r_opsel <= bus.operation_select_in;
        r_mats  <= {bus.matrix2_in, bus.matrix1_in};
      end
      if (w_cap) begin
        r_result[{r_idx[3:0], 3'b000} +: 8] <= bus.cpu_data_in;
      end
    end
  end

  assign bus.ready_out        = w_ready;
  assign bus.instruction_out  = r_instr;
  assign bus.result_valid_out = r_valid;
  assign bus.result_data_out  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_tensor_host_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_tensor_host_sequencer                                             |
// | Directed bench with a behavioural tensor CPU and a READ-reply stub   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tensor_host_sequencer;

`ifdef TENSOR_HOST_SEQ_RESET_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  localparam logic [71:0] c_IDENT  = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [71:0] c_SEQ9   = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] c_NEGI   = 72'hFF_00_00_00_FF_00_00_00_FF;
  localparam logic [71:0] c_NEGSEQ = 72'hF7_F8_F9_FA_FB_FC_FD_FE_FF;
  localparam logic [71:0] c_STUB   = 72'h00_00_00_00_F6_00_00_00_00;

  typedef struct {
    int          cyc;
    logic [15:0] instr;
    logic        rdy;
    logic        vld;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   stub_mode;

  logic [15:0] tr_instr [0:63];
  logic        tr_rdy   [0:63];
  logic        tr_vld   [0:63];
  vec_t        tbl      [14];

  logic [7:0]  cpu_regs [0:31];
  int          cpu_timer;
  logic [7:0]  cpu_byte;

  tensor_host_sequencer_if bus_if ();

  tensor_host_sequencer #(.WAIT_CYCLES(5)) dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CPU: LOADI writes, OPERATE schedules a 3x3 int8 matmul 4 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_timer <= 0;
      for (int r = 0; r < 32; r++) cpu_regs[r] <= 8'h00;
    end else begin
      if (bus_if.instruction_out[1:0] == 2'b01)
        cpu_regs[bus_if.instruction_out[15:11]] <= bus_if.instruction_out[10:3];
      if (bus_if.instruction_out[1:0] == 2'b10)
        cpu_timer <= 4;
      else if (bus_if.instruction_out == 16'h000C)
        cpu_timer <= 0;
      else if (cpu_timer > 0)
        cpu_timer <= cpu_timer - 1;
      if (cpu_timer == 1) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 3; k++)
              acc += $signed(cpu_regs[3*i+k]) * $signed(cpu_regs[9+3*k+j]);
            cpu_regs[3*i+j] <= acc[7:0];
          end
        end
      end
    end
  end

  always_comb begin
    cpu_byte = 8'h00;
    if (bus_if.instruction_out[15:11] == 5'd0 && bus_if.instruction_out[5:0] == 6'b001000) begin
      if (stub_mode != 0)
        cpu_byte = (bus_if.instruction_out[10:6] == 5'd4) ? 8'hF6 : 8'h00;
      else
        cpu_byte = cpu_regs[bus_if.instruction_out[10:6]];
    end
  end
  assign bus_if.cpu_data_in = cpu_byte;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic start_and_trace(input int n);
    @(negedge clk);
    bus_if.start_in = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus_if.start_in = 1'b0;
      tr_instr[k] = bus_if.instruction_out;
      tr_rdy[k]   = bus_if.ready_out;
      tr_vld[k]   = bus_if.result_valid_out;
    end
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    bus_if.result_ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus_if.result_ready_in = 1'b0;
    chk({nm, "_valid_drop"}, bus_if.result_valid_out, 1'b0);
    chk({nm, "_ready_back"}, bus_if.ready_out, 1'b1);
  endtask

  initial begin
    int op_at;
    int rd_at;
    n_checks = 0;
    n_fail = 0;
    stub_mode = 0;
    rst_n = 1'b0;
    bus_if.start_in = 1'b0;
    bus_if.result_ready_in = 1'b0;
    bus_if.operation_select_in = 3'd0;
    bus_if.matrix1_in = c_IDENT;
    bus_if.matrix2_in = c_SEQ9;

    tbl[0]  = '{1,  16'h0009, 1'b0, 1'b0};
    tbl[1]  = '{2,  16'h0801, 1'b0, 1'b0};
    tbl[2]  = '{5,  16'h2009, 1'b0, 1'b0};
    tbl[3]  = '{9,  16'h4009, 1'b0, 1'b0};
    tbl[4]  = '{10, 16'h4809, 1'b0, 1'b0};
    tbl[5]  = '{17, 16'h8041, 1'b0, 1'b0};
    tbl[6]  = '{18, 16'h8849, 1'b0, 1'b0};
    tbl[7]  = '{19, 16'h0002, 1'b0, 1'b0};
    tbl[8]  = '{20, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{24, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{25, 16'h0008, 1'b0, 1'b0};
    tbl[11] = '{26, 16'h0048, 1'b0, 1'b0};
    tbl[12] = '{33, 16'h0208, 1'b0, 1'b0};
    tbl[13] = '{34, 16'h0000, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_instr", bus_if.instruction_out, 16'h0000);
    chk("reset_ready", bus_if.ready_out, 1'b1);
    chk("reset_valid", bus_if.result_valid_out, 1'b0);
    chk("reset_data", bus_if.result_data_out, 72'h0);

    // Identity x {1..9} against the behavioural CPU
    start_and_trace(36 + SH);
`ifdef TENSOR_HOST_SEQ_RESET_EN
    chk("reset_issue_instr", tr_instr[1], 16'h000C);
`endif
    for (int v = 0; v < 14; v++) begin
      chk($sformatf("ident_instr_c%0d", tbl[v].cyc), tr_instr[tbl[v].cyc + SH], tbl[v].instr);
      chk($sformatf("ident_ready_c%0d", tbl[v].cyc), tr_rdy[tbl[v].cyc + SH], tbl[v].rdy);
      chk($sformatf("ident_valid_c%0d", tbl[v].cyc), tr_vld[tbl[v].cyc + SH], tbl[v].vld);
    end
    op_at = 0;
    rd_at = 0;
    for (int k = 1; k <= 36 + SH; k++) begin
      if (tr_instr[k] == 16'h0002 && op_at == 0) op_at = k;
      if (tr_instr[k] == 16'h0008 && rd_at == 0) rd_at = k;
    end
    chk("ident_operate_cycle", 72'(op_at), 72'(19 + SH));
    chk("ident_nop_count", 72'(rd_at - op_at - 1), 72'd5);
    chk("ident_result", bus_if.result_data_out, c_SEQ9);

    // Backpressure with a start pulse that must be ignored
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus_if.start_in = (c == 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("hold_instr_%0d", c), bus_if.instruction_out, 16'h0000);
      chk($sformatf("hold_ready_%0d", c), bus_if.ready_out, 1'b0);
      chk($sformatf("hold_valid_%0d", c), bus_if.result_valid_out, 1'b1);
      chk($sformatf("hold_data_%0d", c), bus_if.result_data_out, c_SEQ9);
    end
    handshake("hold_hs");
    chk("hold_data_kept", bus_if.result_data_out, c_SEQ9);
    @(negedge clk);
    chk("hold_no_restart", bus_if.instruction_out, 16'h0000);

    // Signed passthrough via stub replying 0xF6 on READ addr 4 only
    stub_mode = 1;
    bus_if.matrix1_in = c_SEQ9;
    bus_if.matrix2_in = c_NEGI;
    start_and_trace(35 + SH);
    chk("stub_valid_early", tr_vld[33 + SH], 1'b0);
    chk("stub_valid_on_time", tr_vld[34 + SH], 1'b1);
    chk("stub_result", bus_if.result_data_out, c_STUB);

    // Back-to-back: handshake, then start on the following cycle
    handshake("b2b_hs");
    chk("b2b_instr_at_hs", bus_if.instruction_out, 16'h0000);
    stub_mode = 0;
    bus_if.matrix1_in = c_IDENT;
    bus_if.matrix2_in = c_SEQ9;
    @(negedge clk);
    bus_if.start_in = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start_in = 1'b0;
`ifdef TENSOR_HOST_SEQ_RESET_EN
    chk("b2b_reset_issue", bus_if.instruction_out, 16'h000C);
    @(posedge clk);
    #1;
`endif
    chk("b2b_first_loadi", bus_if.instruction_out, 16'h0009);

    // Reset during LOAD drops the instruction immediately
    repeat (4) @(posedge clk);
    #1;
    chk("load_instr_before_rst", bus_if.instruction_out, 16'h2009);
    #2;
    rst_n = 1'b0;
    #1;
    chk("load_rst_instr", bus_if.instruction_out, 16'h0000);
    chk("load_rst_ready", bus_if.ready_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT cycle 2
    start_and_trace(21 + SH);
    chk("wait_job_operate", tr_instr[19 + SH], 16'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wait_rst_instr", bus_if.instruction_out, 16'h0000);
    chk("wait_rst_valid", bus_if.result_valid_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wait_rel_ready", bus_if.ready_out, 1'b1);
    chk("wait_rel_valid", bus_if.result_valid_out, 1'b0);

    // Normal job after the aborted ones: {1..9} x -I
    bus_if.operation_select_in = 3'd0;
    bus_if.matrix1_in = c_SEQ9;
    bus_if.matrix2_in = c_NEGI;
    start_and_trace(36 + SH);
    chk("neg_first_loadi", tr_instr[1 + SH], 16'h0009);
    chk("neg_valid_early", tr_vld[33 + SH], 1'b0);
    chk("neg_valid_on_time", tr_vld[34 + SH], 1'b1);
    chk("neg_result", bus_if.result_data_out, c_NEGSEQ);
    handshake("neg_hs");
    chk("neg_data_kept", bus_if.result_data_out, c_NEGSEQ);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
